ahb_req_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one ahb_master among NREQ requesters.

---
 rtl/ahb_req_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ahb_req_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_req_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_req_arbiter
//
// Round-robin arbiter and sequencer that shares one ahb_master among NREQ
// requesters. One request is accepted at a time. Its address, write flag and
// write data are latched and driven to the master. A single-cycle enable pulse
// starts the transfer. The arbiter then follows the master through its
// idle -> control -> data -> idle sequence by watching hreadyout. When the
// transfer finishes, the winning requester receives a one-cycle ack, and read
// data is returned on rdata.
//
// Ports
//   hclk        in   1        bus clock, rising edge
//   hreset      in   1        synchronous, active-high reset
//   req         in   NREQ     per-requester request, held until matching ack
//   req_wr      in   NREQ     1 = write, 0 = read (valid while req high)
//   req_addr    in   NREQ*32  packed addresses, requester i at [i*32+:32]
//   req_wdata   in   NREQ*32  packed write data, same layout
//   gnt         out  NREQ     one-hot owner of the master, ISSUE..DONE
//   ack         out  NREQ     one-hot single-cycle completion pulse
//   rdata       out  32       read data, valid while ack is high
//   m_enable    out  1        to ahb_master.enable
//   m_addr      out  32       to ahb_master.addr
//   m_din       out  32       to ahb_master.din
//   m_wr        out  1        to ahb_master.wr
//   m_dout      in   32       from ahb_master.dout
//   hreadyout   in   1        slave ready, same net the master sees
//
// All outputs come straight from flops, so they are glitch-free.
// ----------------------------------------------------------------------------
module ahb_req_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          rdata,
    output logic                 m_enable,
    output logic [31:0]          m_addr,
    output logic [31:0]          m_din,
    output logic                 m_wr,
    input  logic [31:0]          m_dout,
    input  logic                 hreadyout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CTRL  = 3'd2,
        DATA  = 3'd3,
        RESP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                state_r;
    logic [IDXW-1:0]       idx_r;
    logic [IDXW-1:0]       last_r;
    logic [NREQ-1:0]       gnt_r;
    logic [NREQ-1:0]       ack_r;
    logic [31:0]           rdata_r;
    logic                  m_enable_r;
    logic [31:0]           m_addr_r;
    logic [31:0]           m_din_r;
    logic                  m_wr_r;

    // Arbitration results, only consumed while in IDLE
    logic                  pick_found_s;
    logic [IDXW-1:0]       pick_idx_s;
    logic                  hit_s;
    int                    cand_s;
    logic [31:0]           sel_addr_s;
    logic [31:0]           sel_wdata_s;
    logic                  sel_wr_s;

    // Convert a requester index into its one-hot grant/ack vector.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = {NREQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Round-robin search: the first set request after the last winner, wrapping modulo NREQ.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = {IDXW{1'b0}};
        hit_s        = 1'b0;
        cand_s       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s       = (int'(last_r) + k) % NREQ;
            hit_s        = !pick_found_s && req[cand_s[IDXW-1:0]];
            pick_idx_s   = hit_s ? IDXW'(cand_s) : pick_idx_s;
            pick_found_s = pick_found_s | hit_s;
        end
    end

    // Select the winning requester's address, data and direction from the packed buses.
    always_comb begin
        sel_addr_s  = 32'd0;
        sel_wdata_s = 32'd0;
        sel_wr_s    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sel_addr_s  = (pick_idx_s == IDXW'(i)) ? req_addr[i*32 +: 32]  : sel_addr_s;
            sel_wdata_s = (pick_idx_s == IDXW'(i)) ? req_wdata[i*32 +: 32] : sel_wdata_s;
            sel_wr_s    = (pick_idx_s == IDXW'(i)) ? req_wr[i]             : sel_wr_s;
        end
    end

    // Sequencer FSM with registered outputs; a reset mid-transfer aborts it without ack.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r    <= IDLE;
            idx_r      <= {IDXW{1'b0}};
            last_r     <= IDXW'(NREQ - 1);
            gnt_r      <= {NREQ{1'b0}};
            ack_r      <= {NREQ{1'b0}};
            rdata_r    <= 32'd0;
            m_enable_r <= 1'b0;
            m_addr_r   <= 32'd0;
            m_din_r    <= 32'd0;
            m_wr_r     <= 1'b0;
        end else begin
            // Pulse-type outputs default low; only one state raises each of them.
            m_enable_r <= 1'b0;
            ack_r      <= {NREQ{1'b0}};
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        idx_r      <= pick_idx_s;
                        gnt_r      <= idx_to_onehot(pick_idx_s);
                        m_addr_r   <= sel_addr_s;
                        m_din_r    <= sel_wdata_s;
                        m_wr_r     <= sel_wr_s;
                        // The enable flop is high for exactly the ISSUE cycle.
                        m_enable_r <= 1'b1;
                        state_r    <= ISSUE;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ISSUE: begin
                    state_r <= CTRL;
                end
                CTRL: begin
                    state_r <= DATA;
                end
                DATA: begin
                    // The slave may stall indefinitely; no timeout by design.
                    if (hreadyout) begin
                        state_r <= RESP;
                    end else begin
                        state_r <= DATA;
                    end
                end
                RESP: begin
                    // The master holds hrdata on dout once it is back in idle.
                    rdata_r <= m_wr_r ? 32'd0 : m_dout;
                    ack_r   <= idx_to_onehot(idx_r);
                    state_r <= DONE;
                end
                DONE: begin
                    // Requester drops req at this edge, so no arbitration happens here.
                    last_r   <= idx_r;
                    gnt_r    <= {NREQ{1'b0}};
                    rdata_r  <= 32'd0;
                    m_addr_r <= 32'd0;
                    m_din_r  <= 32'd0;
                    m_wr_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    gnt_r    <= {NREQ{1'b0}};
                    rdata_r  <= 32'd0;
                    m_addr_r <= 32'd0;
                    m_din_r  <= 32'd0;
                    m_wr_r   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = gnt_r;
    assign ack      = ack_r;
    assign rdata    = rdata_r;
    assign m_enable = m_enable_r;
    assign m_addr   = m_addr_r;
    assign m_din    = m_din_r;
    assign m_wr     = m_wr_r;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed testbench for ahb_req_arbiter (NREQ = 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ahb_req_arbiter;

    logic           hclk = 1'b0;
    logic           hreset = 1'b1;
    logic [3:0]     req = 4'b0000;
    logic [3:0]     req_wr = 4'b0000;
    logic [127:0]   req_addr = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    logic [127:0]   req_wdata = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    logic [3:0]     gnt;
    logic [3:0]     ack;
    logic [31:0]    rdata;
    logic           m_enable;
    logic [31:0]    m_addr;
    logic [31:0]    m_din;
    logic           m_wr;
    logic [31:0]    m_dout = 32'd0;
    logic           hreadyout = 1'b1;

    int total = 0;
    int bad = 0;

    ahb_req_arbiter #(.NREQ(4), .IDXW(2)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .m_enable  (m_enable),
        .m_addr    (m_addr),
        .m_din     (m_din),
        .m_wr      (m_wr),
        .m_dout    (m_dout),
        .hreadyout (hreadyout)
    );

    always #5 hclk = ~hclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        int n;
        logic [3:0] exp_g;
        req = 4'b1111;
        hreset = 1'b1;
        repeat (2) @(negedge hclk);
        total++; if (gnt !== 4'b0000)   begin bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        total++; if (ack !== 4'b0000)   begin bad++; $display("FAIL rst_ack got=%b exp=0000", ack); end
        total++; if (m_enable !== 1'b0) begin bad++; $display("FAIL rst_m_enable got=%b exp=0", m_enable); end
        total++; if (m_wr !== 1'b0)     begin bad++; $display("FAIL rst_m_wr got=%b exp=0", m_wr); end
        total++; if (m_addr !== 32'd0)  begin bad++; $display("FAIL rst_m_addr got=%h exp=0", m_addr); end
        total++; if (m_din !== 32'd0)   begin bad++; $display("FAIL rst_m_din got=%h exp=0", m_din); end
        total++; if (rdata !== 32'd0)   begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        hreset = 1'b0;
        for (int g = 0; g < 4; g++) begin
            exp_g = 4'b0001 << g;
            n = 0;
            while (m_enable !== 1'b1 && n < 20) begin @(negedge hclk); n++; end
            total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", g, gnt, exp_g); end
            n = 0;
            while (ack === 4'b0000 && n < 20) begin @(negedge hclk); n++; end
            total++; if (ack !== exp_g) begin bad++; $display("FAIL rr_ack[%0d] got=%b exp=%b", g, ack, exp_g); end
            req = req & ~exp_g;
        end
        @(negedge hclk);
    endtask

    task automatic test_read;
        logic [3:0] exp_ack;
        req_addr[64 +: 32] = 32'h0000_0010;
        req_wr[2] = 1'b0;
        m_dout = 32'hCAFE_F00D;
        hreadyout = 1'b1;
        req = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            @(negedge hclk);
            exp_ack = (k == 5) ? 4'b0100 : 4'b0000;
            total++; if (m_enable !== (k == 1)) begin bad++; $display("FAIL rd_m_enable k=%0d got=%b", k, m_enable); end
            total++; if (ack !== exp_ack) begin bad++; $display("FAIL rd_ack k=%0d got=%b exp=%b", k, ack, exp_ack); end
            total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rd_gnt k=%0d got=%b exp=0100", k, gnt); end
            total++; if (m_addr !== 32'h0000_0010) begin bad++; $display("FAIL rd_m_addr k=%0d got=%h exp=00000010", k, m_addr); end
            total++; if (m_wr !== 1'b0) begin bad++; $display("FAIL rd_m_wr k=%0d got=%b exp=0", k, m_wr); end
            if (k == 2) req_addr[64 +: 32] = 32'h9999_0000;
        end
        total++; if (rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rd_rdata got=%h exp=cafef00d", rdata); end
        req = 4'b0000;
        @(negedge hclk);
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rd_gnt_clear got=%b exp=0000", gnt); end
        total++; if (m_addr !== 32'd0) begin bad++; $display("FAIL rd_addr_clear got=%h exp=0", m_addr); end
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rd_ack_clear got=%b exp=0000", ack); end
    endtask

    task automatic test_write;
        logic [3:0] exp_ack;
        req_wdata[32 +: 32] = 32'h1234_5678;
        req_addr[32 +: 32] = 32'h0000_0044;
        req_wr[1] = 1'b1;
        m_dout = 32'hDEAD_BEEF;
        hreadyout = 1'b0;
        req = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            @(negedge hclk);
            exp_ack = (k == 8) ? 4'b0010 : 4'b0000;
            total++; if (m_enable !== (k == 1)) begin bad++; $display("FAIL wr_m_enable k=%0d got=%b", k, m_enable); end
            total++; if (ack !== exp_ack) begin bad++; $display("FAIL wr_ack k=%0d got=%b exp=%b", k, ack, exp_ack); end
            total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL wr_gnt k=%0d got=%b exp=0010", k, gnt); end
            total++; if (m_din !== 32'h1234_5678) begin bad++; $display("FAIL wr_m_din k=%0d got=%h exp=12345678", k, m_din); end
            total++; if (m_wr !== 1'b1) begin bad++; $display("FAIL wr_m_wr k=%0d got=%b exp=1", k, m_wr); end
            total++; if (m_addr !== 32'h0000_0044) begin bad++; $display("FAIL wr_m_addr k=%0d got=%h exp=00000044", k, m_addr); end
            if (k == 1) req_wdata[32 +: 32] = 32'h0BAD_0BAD;
            if (k == 6) hreadyout = 1'b1;
        end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", rdata); end
        req = 4'b0000;
        req_wr[1] = 1'b0;
        @(negedge hclk);
    endtask

    task automatic test_fairness;
        int n;
        logic [3:0] seq [4];
        seq[0] = 4'b0001; seq[1] = 4'b1000; seq[2] = 4'b0001; seq[3] = 4'b1000;
        hreset = 1'b1;
        @(negedge hclk);
        hreset = 1'b0;
        hreadyout = 1'b1;
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (ack === 4'b0000 && n < 20) begin @(negedge hclk); n++; end
            total++; if (ack !== seq[i]) begin bad++; $display("FAIL fair_ack[%0d] got=%b exp=%b", i, ack, seq[i]); end
            if (i < 3) begin
                @(negedge hclk);
                total++; if (m_enable !== 1'b0) begin bad++; $display("FAIL fair_gap_en[%0d] got=%b exp=0", i, m_enable); end
                total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL fair_gap_gnt[%0d] got=%b exp=0000", i, gnt); end
                @(negedge hclk);
                total++; if (m_enable !== 1'b1) begin bad++; $display("FAIL fair_next_en[%0d] got=%b exp=1", i, m_enable); end
                total++; if (gnt !== seq[i+1]) begin bad++; $display("FAIL fair_next_gnt[%0d] got=%b exp=%b", i, gnt, seq[i+1]); end
            end
        end
        req = 4'b0000;
        @(negedge hclk);
    endtask

    task automatic test_reset_mid;
        int n;
        hreadyout = 1'b1;
        req = 4'b0100;
        n = 0;
        while (ack === 4'b0000 && n < 20) begin @(negedge hclk); n++; end
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL rm_pre_ack got=%b exp=0100", ack); end
        req = 4'b0000;
        @(negedge hclk);
        hreadyout = 1'b0;
        req = 4'b1000;
        repeat (3) @(negedge hclk);
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL rm_data_gnt got=%b exp=1000", gnt); end
        total++; if (m_enable !== 1'b0) begin bad++; $display("FAIL rm_data_en got=%b exp=0", m_enable); end
        req = 4'b1010;
        hreset = 1'b1;
        @(negedge hclk);
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rm_gnt got=%b exp=0000", gnt); end
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rm_ack got=%b exp=0000", ack); end
        total++; if (m_enable !== 1'b0) begin bad++; $display("FAIL rm_en got=%b exp=0", m_enable); end
        total++; if (m_addr !== 32'd0) begin bad++; $display("FAIL rm_addr got=%h exp=0", m_addr); end
        hreset = 1'b0;
        hreadyout = 1'b1;
        @(negedge hclk);
        total++; if (m_enable !== 1'b1) begin bad++; $display("FAIL rm_next_en got=%b exp=1", m_enable); end
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rm_next_gnt got=%b exp=0010", gnt); end
        n = 0;
        while (ack === 4'b0000 && n < 20) begin @(negedge hclk); n++; end
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL rm_next_ack got=%b exp=0010", ack); end
        req = 4'b1000;
        @(negedge hclk);
        n = 0;
        while (ack === 4'b0000 && n < 20) begin @(negedge hclk); n++; end
        total++; if (ack !== 4'b1000) begin bad++; $display("FAIL rm_last_ack got=%b exp=1000", ack); end
        req = 4'b0000;
        @(negedge hclk);
    endtask

    task automatic test_stall;
        int en_seen;
        en_seen = 0;
        hreadyout = 1'b0;
        req = 4'b0001;
        repeat (2) @(negedge hclk);
        for (int k = 3; k <= 22; k++) begin
            @(negedge hclk);
            if (m_enable === 1'b1) en_seen++;
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL st_gnt k=%0d got=%b exp=0001", k, gnt); end
            total++; if (ack !== 4'b0000) begin bad++; $display("FAIL st_ack k=%0d got=%b exp=0000", k, ack); end
        end
        total++; if (en_seen !== 0) begin bad++; $display("FAIL st_extra_enable got=%0d exp=0", en_seen); end
        hreadyout = 1'b1;
        @(negedge hclk);
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL st_resp_ack got=%b exp=0000", ack); end
        @(negedge hclk);
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL st_done_ack got=%b exp=0001", ack); end
        total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL st_rdata got=%h exp=deadbeef", rdata); end
        req = 4'b0000;
        @(negedge hclk);
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_fairness;
        test_reset_mid;
        test_stall;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
